// File: rtl/xrv_pkg.sv
// Shared xriscv types: load/store access size, LSU FSM states and the size decode.
package xrv_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } ls_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_e;

   // Encoding 2'b11 is reserved and behaves as a word access.
   function automatic ls_size_e decode_size(input logic [1:0] raw);
      case (raw)
         2'b00:   return BYTE;
         2'b01:   return HALF;
         default: return WORD;
      endcase
   endfunction

endpackage

// File: rtl/xrv_lsu_if.sv
// Data bus between the LSU (master) and the memory fabric (slave).
// Handshake: d_req is held with stable d_addr/d_we/d_be/d_wdata until the cycle d_gnt is high;
// a granted read returns exactly one d_rvalid/d_rdata beat, no earlier than the cycle after d_gnt.
interface xrv_lsu_if;
   logic        d_req;
   logic        d_gnt;
   logic [31:0] d_addr;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_wdata;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   modport master (
      output d_req, d_addr, d_we, d_be, d_wdata,
      input  d_gnt, d_rvalid, d_rdata
   );

   modport slave (
      input  d_req, d_addr, d_we, d_be, d_wdata,
      output d_gnt, d_rvalid, d_rdata
   );
endinterface

// File: rtl/xrv_lsu_align.sv
// Combinational lane logic: byte enables, store replication, misalign check and load extend.
module xrv_lsu_align
   import xrv_pkg::*;
(
   input  ls_size_e    size,
   input  logic [1:0]  off,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic        misalign,
   output logic [31:0] rdata_ext
);

   logic [31:0] shifted;

   always_comb begin
      be         = 4'hF;
      wdata_lane = wdata;
      misalign   = 1'b0;
      shifted    = rdata >> {off, 3'b000};
      rdata_ext  = rdata;
      case (size)
         BYTE: begin
            be         = 4'b0001 << off;
            wdata_lane = {4{wdata[7:0]}};
            rdata_ext  = is_unsigned ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         end
         HALF: begin
            be         = 4'b0011 << {off[1], 1'b0};
            wdata_lane = {2{wdata[15:0]}};
            misalign   = off[0];
            rdata_ext  = is_unsigned ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         end
         default: begin
            misalign = (off != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/xrv_lsu.sv
// Load/store unit: one access per is_ls, run on the data bus; kill mid-transaction lets the bus
// complete but suppresses ls_done.
module xrv_lsu
   import xrv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        is_ls,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic        ls_unsigned,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   input  logic        kill,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   output logic        ls_misalign,
   output lsu_state_e  dbg_state,
   xrv_lsu_if.master   bus
);

   lsu_state_e  state, state_n;
   ls_size_e    req_size;
   logic [1:0]  req_off;
   logic        req_unsigned;
   logic        killed;
   logic        accept;

   ls_size_e    a_size;
   logic [1:0]  a_off;
   logic        a_unsigned;
   logic [3:0]  a_be;
   logic [31:0] a_wdata;
   logic        a_mis;
   logic [31:0] a_rdata;

   // Live request fields drive the aligner in IDLE; afterwards the captured ones do, for extraction.
   assign a_size     = (state == IDLE) ? decode_size(ls_size) : req_size;
   assign a_off      = (state == IDLE) ? ls_addr[1:0] : req_off;
   assign a_unsigned = (state == IDLE) ? ls_unsigned : req_unsigned;

   xrv_lsu_align u_align (
      .size        (a_size),
      .off         (a_off),
      .is_unsigned (a_unsigned),
      .wdata       (ls_wdata),
      .rdata       (bus.d_rdata),
      .be          (a_be),
      .wdata_lane  (a_wdata),
      .misalign    (a_mis),
      .rdata_ext   (a_rdata)
   );

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      case (state)
         IDLE: begin
            if (is_ls && !kill) begin
               accept  = 1'b1;
               state_n = a_mis ? DONE : REQ;
            end
         end
         REQ: begin
            if (bus.d_gnt) begin
               if (bus.d_we) state_n = (killed || kill) ? IDLE : DONE;
               else          state_n = WAIT;
            end
         end
         WAIT: begin
            if (bus.d_rvalid) state_n = (killed || kill) ? IDLE : DONE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         req_size     <= BYTE;
         req_off      <= 2'b00;
         req_unsigned <= 1'b0;
         killed       <= 1'b0;
         ls_done      <= 1'b0;
         ls_misalign  <= 1'b0;
         ls_rdata     <= 32'd0;
         bus.d_req    <= 1'b0;
         bus.d_addr   <= 32'd0;
         bus.d_we     <= 1'b0;
         bus.d_be     <= 4'd0;
         bus.d_wdata  <= 32'd0;
      end else begin
         state       <= state_n;
         bus.d_req   <= (state_n == REQ);
         ls_done     <= (state_n == DONE);
         ls_misalign <= 1'b0;
         killed      <= (state_n == REQ || state_n == WAIT) && (killed || kill);
         if (accept) begin
            req_size     <= a_size;
            req_off      <= ls_addr[1:0];
            req_unsigned <= ls_unsigned;
            ls_rdata     <= 32'd0;
            if (a_mis) begin
               ls_misalign <= 1'b1;
            end else begin
               bus.d_addr  <= {ls_addr[31:2], 2'b00};
               bus.d_we    <= ls_we;
               bus.d_be    <= a_be;
               bus.d_wdata <= a_wdata;
            end
         end
         if (state == WAIT && bus.d_rvalid) ls_rdata <= a_rdata;
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_xrv_lsu.sv
// Bench for xrv_lsu: directed cases plus randomized accesses checked against a byte-level model.
module tb_xrv_lsu;
   import xrv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        is_ls, ls_we, ls_unsigned, kill;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr, ls_wdata;
   logic        ls_done, ls_misalign;
   logic [31:0] ls_rdata;
   lsu_state_e  dbg_state;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   xrv_lsu_if bus();

   xrv_lsu dut (
      .clk         (clk),
      .rst         (rst),
      .is_ls       (is_ls),
      .ls_we       (ls_we),
      .ls_size     (ls_size),
      .ls_unsigned (ls_unsigned),
      .ls_addr     (ls_addr),
      .ls_wdata    (ls_wdata),
      .kill        (kill),
      .ls_done     (ls_done),
      .ls_rdata    (ls_rdata),
      .ls_misalign (ls_misalign),
      .dbg_state   (dbg_state),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Reference model: memory seen as four byte lanes of the addressed word.
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit m_mis(input logic [31:0] addr, input logic [1:0] sz);
      return (addr % nbytes(sz)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [31:0] addr, input logic [1:0] sz);
      logic [3:0] b = 4'd0;
      int idx = int'(addr % 4);
      for (int k = 0; k < nbytes(sz); k++) b[idx + k] = 1'b1;
      return b;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] sz);
      logic [31:0] r;
      for (int j = 0; j < 4; j++) r[8*j +: 8] = wd[8*(j % nbytes(sz)) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [1:0] sz,
                                          input bit uns, input logic [31:0] rd);
      longint v = 0;
      int n = nbytes(sz);
      int idx = int'(addr % 4);
      for (int k = 0; k < n; k++) v += longint'(rd[8*(idx + k) +: 8]) << (8*k);
      if (!uns && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
      return v[31:0];
   endfunction

   task automatic run_ls(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int gnt_dly, input int rv_dly);
      logic [31:0] exp_v;
      bit mis;
      mis = m_mis(addr, sz);
      is_ls = 1'b1; ls_we = we; ls_size = sz; ls_unsigned = uns; ls_addr = addr; ls_wdata = wd;
      if (mis)     exp_q.push_back(32'd0);
      else if (!we) exp_q.push_back(m_load(addr, sz, uns, rd));
      tick();
      if (mis) begin
         exp_v = exp_q.pop_front();
         chk("mis_done", 32'(ls_done), 32'd1);
         chk("mis_flag", 32'(ls_misalign), 32'd1);
         chk("mis_req", 32'(bus.d_req), 32'd0);
         chk("mis_rdata", ls_rdata, exp_v);
      end else begin
         for (int i = 0; i <= gnt_dly; i++) begin
            chk("req", 32'(bus.d_req), 32'd1);
            chk("addr", bus.d_addr, addr & 32'hFFFF_FFFC);
            chk("be", 32'(bus.d_be), 32'(m_be(addr, sz)));
            chk("we", 32'(bus.d_we), 32'(we));
            if (we) chk("wdata", bus.d_wdata, m_wdata(wd, sz));
            chk("early_done", 32'(ls_done), 32'd0);
            bus.d_gnt = (i == gnt_dly);
            tick();
         end
         bus.d_gnt = 1'b0;
         if (!we) begin
            for (int i = 0; i <= rv_dly; i++) begin
               chk("wait_req", 32'(bus.d_req), 32'd0);
               chk("wait_done", 32'(ls_done), 32'd0);
               bus.d_rvalid = (i == rv_dly);
               bus.d_rdata  = (i == rv_dly) ? rd : $urandom;
               tick();
            end
            bus.d_rvalid = 1'b0;
            exp_v = exp_q.pop_front();
            chk("ld_rdata", ls_rdata, exp_v);
         end
         chk("done", 32'(ls_done), 32'd1);
         chk("done_mis", 32'(ls_misalign), 32'd0);
      end
      // is_ls still high here: the DONE cycle must not re-accept it.
      tick();
      chk("pulse", 32'(ls_done), 32'd0);
      chk("no_reaccept", 32'(bus.d_req), 32'd0);
      chk("idle", 32'(dbg_state), 32'(IDLE));
      is_ls = 1'b0;
   endtask

   initial begin
      rst = 1'b1; is_ls = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_unsigned = 1'b0;
      ls_addr = 32'd0; ls_wdata = 32'd0; kill = 1'b0;
      bus.d_gnt = 1'b0; bus.d_rvalid = 1'b0; bus.d_rdata = 32'd0;
      repeat (3) tick();
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      chk("rst_done", 32'(ls_done), 32'd0);
      chk("rst_mis", 32'(ls_misalign), 32'd0);
      chk("rst_req", 32'(bus.d_req), 32'd0);
      chk("rst_we", 32'(bus.d_we), 32'd0);
      chk("rst_be", 32'(bus.d_be), 32'd0);
      chk("rst_addr", bus.d_addr, 32'd0);
      chk("rst_wdata", bus.d_wdata, 32'd0);
      chk("rst_rdata", ls_rdata, 32'd0);
      rst = 1'b0;
      tick();

      // Directed cases
      run_ls(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'd0, 0, 0);
      run_ls(1'b0, 2'd0, 1'b0, 32'h0000_2002, 32'd0, 32'h0080_0000, 0, 0);
      run_ls(1'b0, 2'd0, 1'b1, 32'h0000_2002, 32'd0, 32'h0080_0000, 0, 1);
      run_ls(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'd0, 32'h8001_0000, 1, 0);
      run_ls(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'd0, 32'd0, 0, 0);
      run_ls(1'b1, 2'd1, 1'b0, 32'h0000_4002, 32'h1234_BEEF, 32'd0, 5, 0);
      run_ls(1'b0, 2'd3, 1'b0, 32'h0000_5000, 32'd0, 32'hDEAD_BEEF, 0, 2);

      // Kill while waiting for rvalid: bus completes, no ls_done
      is_ls = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h0000_6000;
      tick();
      chk("kw_req", 32'(bus.d_req), 32'd1);
      bus.d_gnt = 1'b1; tick(); bus.d_gnt = 1'b0;
      chk("kw_wait", 32'(dbg_state), 32'(WAIT));
      kill = 1'b1; is_ls = 1'b0; tick(); kill = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("kw_nodone", 32'(ls_done), 32'd0);
         tick();
      end
      bus.d_rvalid = 1'b1; bus.d_rdata = 32'h1111_2222; tick(); bus.d_rvalid = 1'b0;
      chk("kw_done", 32'(ls_done), 32'd0);
      chk("kw_idle", 32'(dbg_state), 32'(IDLE));
      tick();
      chk("kw_done2", 32'(ls_done), 32'd0);
      run_ls(1'b0, 2'd1, 1'b1, 32'h0000_6006, 32'd0, 32'hF00D_0000, 0, 0);

      // Kill in REQ: d_req held until grant, then silent return to IDLE
      is_ls = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h0000_7000; ls_wdata = 32'h5555_AAAA;
      tick();
      kill = 1'b1; is_ls = 1'b0; tick(); kill = 1'b0;
      chk("kr_hold", 32'(bus.d_req), 32'd1);
      tick();
      chk("kr_hold2", 32'(bus.d_req), 32'd1);
      bus.d_gnt = 1'b1; tick(); bus.d_gnt = 1'b0;
      chk("kr_done", 32'(ls_done), 32'd0);
      chk("kr_idle", 32'(dbg_state), 32'(IDLE));
      chk("kr_req", 32'(bus.d_req), 32'd0);

      // Kill in IDLE blocks acceptance; stray rvalid in IDLE is ignored
      is_ls = 1'b1; kill = 1'b1; tick(); kill = 1'b0; is_ls = 1'b0;
      chk("ki_req", 32'(bus.d_req), 32'd0);
      chk("ki_idle", 32'(dbg_state), 32'(IDLE));
      bus.d_rvalid = 1'b1; tick(); bus.d_rvalid = 1'b0;
      chk("rv_idle_done", 32'(ls_done), 32'd0);
      chk("rv_idle_state", 32'(dbg_state), 32'(IDLE));

      // Reset asserted in REQ
      is_ls = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_8000; tick();
      chk("rr_req", 32'(bus.d_req), 32'd1);
      rst = 1'b1; is_ls = 1'b0; tick(); rst = 1'b0;
      chk("rr_req0", 32'(bus.d_req), 32'd0);
      chk("rr_idle", 32'(dbg_state), 32'(IDLE));
      chk("rr_done", 32'(ls_done), 32'd0);
      tick();
      chk("rr_done2", 32'(ls_done), 32'd0);

      // Randomized accesses
      for (int n = 0; n < 150; n++) begin
         run_ls(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      chk("q_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/xrv_lsu.md
# xrv_lsu

Load/store unit for the xriscv core's EX stage. It accepts one load or store per `is_ls` request and runs it on the data bus with a req/gnt/rvalid handshake. It maps byte lanes, sign- or zero-extends load data, and returns a one-cycle `ls_done` pulse to the pipeline control block, which holds the stall until then. Misaligned accesses never reach the bus.

## Interface
- No parameters; the address and data width is fixed at 32.
- `clk` in 1: core clock.
- `rst` in 1: reset. Synchronous, active-high.
- `is_ls` in 1: EX holds a load/store instruction. Held high until `ls_done`.
- `ls_we` in 1: 1 = store, 0 = load.
- `ls_size` in 2: 00 byte, 01 half, 10 word. 11 is treated as word.
- `ls_unsigned` in 1: zero-extend load data (LBU/LHU).
- `ls_addr` in 32: byte address.
- `ls_wdata` in 32: store data, right-aligned.
- `kill` in 1: pipeline jump/flush. Cancels the current access as described under Operation.
- `ls_done` out 1: one-cycle completion pulse.
- `ls_rdata` out 32: extended load result. Valid while `ls_done` is high.
- `ls_misalign` out 1: high with `ls_done` when the access was misaligned.
- `d_req` out 1: bus request.
- `d_gnt` in 1: bus accepts the request in this cycle.
- `d_addr` out 32: word address (bits 1:0 = 0).
- `d_we` out 1: bus write.
- `d_be` out 4: byte enables.
- `d_wdata` out 32: lane-replicated store data.
- `d_rvalid` in 1: read data valid. Earliest one cycle after `d_gnt`.
- `d_rdata` in 32: read data word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on `is_ls & ~kill`, register the request. Then:
  - if aligned: compute `d_addr`, `d_be`, `d_wdata`, `d_we` and go to REQ;
  - if misaligned: go to DONE with the misalign flag set.
- Misaligned means: half with `addr[0]=1`, or word with `addr[1:0]!=0`. Byte accesses are never misaligned.
- REQ: `d_req=1`. Bus outputs stay stable until `d_gnt`. On `d_gnt`: a store goes to DONE, a load goes to WAIT.
- WAIT: on `d_rvalid`, register the extended result into `ls_rdata` and go to DONE.
- DONE: `ls_done=1` for one cycle, then return to IDLE.
  - `is_ls` is ignored in DONE, because it is still asserted for the finishing instruction.
  - IDLE may accept a new request in the very next cycle.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`;
  - half: `4'b0011 << {addr[1],1'b0}`;
  - word: `4'hF`.
- Store data:
  - byte: `{4{wdata[7:0]}}`;
  - half: `{2{wdata[15:0]}}`;
  - word: `wdata` unchanged.
- Load extraction: take `d_rdata >> (8*addr[1:0])`, keep the low 8 or 16 bits, then sign-extend, or zero-extend if `ls_unsigned`. Word loads are passed through unchanged.
- `kill` handling:
  - In IDLE, `kill` blocks acceptance.
  - In REQ or WAIT, the bus transaction still completes: `d_req` is never withdrawn before `d_gnt`, and a load's `rvalid` is always consumed. A sticky `killed` flag is set instead. On completion the FSM goes to IDLE without pulsing `ls_done`, and `killed` is cleared.
  - `kill` in DONE is ignored.
- Misaligned accesses: `ls_rdata=0`, `ls_misalign=1`, no bus activity.

## Timing
- Reset values: state IDLE; `ls_done`, `ls_misalign`, `d_req`, `d_we` = 0; `d_be` = 0; `d_addr`, `d_wdata`, `ls_rdata` = 0; `killed` = 0. Reset takes effect in any state, including mid-transaction; the bus drop is the fabric's concern.
- Store, zero-wait bus: `is_ls` at T0 → `d_req` T1, `d_gnt` T1 → `ls_done` T2.
- Load, zero-wait bus: `d_gnt` T1, `d_rvalid` T2 → `ls_done` and `ls_rdata` at T3.
- Misaligned access: `is_ls` at T0 → `ls_done` and `ls_misalign` at T1.
- Back-to-back: a second `is_ls` (new instruction) at the cycle after `ls_done` is accepted in that cycle.
- All outputs are registered; there is no combinational path from `d_gnt` or `d_rvalid` to any output.
- `d_rvalid` arriving outside WAIT is ignored.

## Structure
- Add `ls_size_e` (BYTE, HALF, WORD) and `lsu_state_e` to the shared package `xrv_pkg`.
- One combinational sub-module, `xrv_lsu_align`. It derives `d_be`, `d_wdata` and the misalign flag from size, address and wdata, and performs the load extract/extend. It is reused by the instruction-fetch misalign checks.
- `xrv_lsu` holds the FSM, the request registers and the `killed` flag.

## Test plan
- Byte store, addr 0x1003, wdata 0xAB, `d_gnt` immediate → `d_addr`=0x1000, `d_be`=1000, `d_wdata`=0xABABABAB, `ls_done` 2 cycles after `is_ls`.
- LB at 0x2002, `d_rdata`=0x0080_0000 → `ls_rdata`=0xFFFFFF80. LBU at the same address → 0x00000080. Half load at 0x2002 with `d_rdata`=0x8001_0000 and `ls_unsigned=0` → `ls_rdata`=0xFFFF8001.
- Word load at 0x3001 → no `d_req`, `ls_done` and `ls_misalign` pulse at T1, `ls_rdata`=0.
- Store with `d_gnt` held low for 5 cycles → `d_req` and the bus outputs stay stable for 5 cycles, `ls_done` exactly 1 cycle after `d_gnt`.
- Load with `kill` asserted in WAIT, `rvalid` 3 cycles later → no `ls_done`. The FSM returns to IDLE, and the next `is_ls` completes normally.
- `rst` asserted in REQ → next cycle `d_req`=0, state IDLE, no `ls_done`.
